opbomp_argmax_seq: RTL

//   Sequential, parametrised successor to the combinational OPBOMP detection stage.

---
 rtl/opbomp_argmax_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/opbomp_argmax_seq.sv
`default_nettype none
//==============================================================================
// Module   : opbomp_argmax_seq
// Purpose  : Sequential argmax of |x[i]| over N signed elements, P lanes/cycle.
//            Optional threshold detector enabled by defining ARGMAX_THRESH_EN.
// Revision : 1.0 - initial release
//==============================================================================
module opbomp_argmax_seq #(
    parameter int N  = 24,
    parameter int W  = 16,
    parameter int P  = 4,
    parameter int IW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  x,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef ARGMAX_THRESH_EN
    input  logic [W-1:0]    thresh,
    output logic            hit,
`endif
    output logic [IW-1:0]   posmax,
    output logic [W:0]      maxabs
);

    localparam int c_NGROUPS = (N + P - 1) / P;
    localparam int c_NLANES  = c_NGROUPS * P;
    localparam int c_GW      = $clog2(c_NGROUPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [W-1:0]      r_lane [c_NLANES];
    logic [W-1:0]      w_load [c_NLANES];
    logic [W-1:0]      w_shift[c_NLANES];
    logic [W:0]        w_ext  [P];
    logic [W:0]        w_mag  [P];

    logic [c_GW-1:0]   r_grp;
    logic [IW-1:0]     r_base;
    logic [W:0]        r_best_mag;
    logic [IW-1:0]     r_best_idx;
    logic [W:0]        w_best_mag;
    logic [IW-1:0]     w_best_idx;
    logic [IW-1:0]     r_posmax;
    logic [W:0]        r_maxabs;

    logic              w_xfer;
    logic              w_ack;
    logic              w_last;

    assign w_ack     = (r_state == S_DONE) && out_ready;
    assign in_ready  = (r_state == S_IDLE) || w_ack;
    assign w_xfer    = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    // Group count G is a commit cycle: compares ran on groups 0..G-1.
    assign w_last    = (r_grp == c_GW'(c_NGROUPS));
    assign posmax    = r_posmax;
    assign maxabs    = r_maxabs;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (w_ack)  w_state_nxt = w_xfer ? S_SCAN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lanes past N are zero-padded; a zero magnitude can never strictly beat the best.
    for (genvar gi = 0; gi < c_NLANES; gi++) begin : g_lane
        if (gi < N) begin : g_in
            assign w_load[gi] = x[gi*W +: W];
        end else begin : g_pad
            assign w_load[gi] = '0;
        end
        if (gi + P < c_NLANES) begin : g_sh
            assign w_shift[gi] = r_lane[gi+P];
        end else begin : g_sh_zero
            assign w_shift[gi] = '0;
        end
    end

    for (genvar gp = 0; gp < P; gp++) begin : g_abs
        assign w_ext[gp] = {r_lane[gp][W-1], r_lane[gp]};
        assign w_mag[gp] = r_lane[gp][W-1] ? -w_ext[gp] : w_ext[gp];
    end

    always_comb begin
        w_best_mag = r_best_mag;
        w_best_idx = r_best_idx;
        for (int p = 0; p < P; p++) begin
            if (w_mag[p] > w_best_mag) begin
                w_best_mag = w_mag[p];
                w_best_idx = r_base + IW'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NLANES; i++) begin
            if (!rst_n)                                r_lane[i] <= '0;
            else if (w_xfer)                           r_lane[i] <= w_load[i];
            else if (r_state == S_SCAN && !w_last)     r_lane[i] <= w_shift[i];
        end
    end

`ifdef ARGMAX_THRESH_EN
    logic [W-1:0] r_thresh;
    logic         r_hit;
    assign hit = r_hit;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grp      <= '0;
            r_base     <= '0;
            r_best_mag <= '0;
            r_best_idx <= '0;
            r_posmax   <= '0;
            r_maxabs   <= '0;
`ifdef ARGMAX_THRESH_EN
            r_thresh   <= '0;
            r_hit      <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_grp      <= '0;
            r_base     <= '0;
            r_best_mag <= '0;
            r_best_idx <= '0;
`ifdef ARGMAX_THRESH_EN
            r_thresh   <= thresh;
`endif
        end else if (r_state == S_SCAN) begin
            if (w_last) begin
                r_posmax <= r_best_idx;
                r_maxabs <= r_best_mag;
`ifdef ARGMAX_THRESH_EN
                r_hit    <= (r_best_mag > {1'b0, r_thresh});
`endif
            end else begin
                r_best_mag <= w_best_mag;
                r_best_idx <= w_best_idx;
                r_base     <= r_base + IW'(P);
                r_grp      <= r_grp + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
